mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Purpose:
//   Steps the select of an external 4:1 mux through channels 0..3. Each channel
//   is held for DWELL cycles; the mux output is captured on the last cycle of
//   the dwell, which leaves DWELL-1 settle cycles after every select change.
//   The four captured bits form a word offered with a valid/ready handshake.
//   With cont high at the handshake the next scan begins immediately.
//
// Parameters:
//   DWELL       cycles spent on each select value (legal range 1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request one scan (only looked at in IDLE)
//   cont        continuous mode (only looked at on the handshake that ends DONE)
//   mux_out     output of the downstream 4:1 mux
//   sel         select driven to the 4:1 mux
//   word        assembled sample, bit i = mux_out captured while sel == i
//   word_valid  word is complete and stable
//   word_ready  consumer accepts word when high together with word_valid
//   busy        high in any state other than IDLE
//   scan_cnt    number of accepted words, modulo 256
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy,
  output logic [7:0] scan_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Dwell counter reload value; the counter runs DWELL-1 down to 0, and the
  // capture happens in the cycle where it reads 0.
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [7:0] dwell_q;
  logic [3:0] word_q;
  logic       valid_q;
  logic       busy_q;
  logic [7:0] cnt_q;

  // Scan FSM: state, select, dwell counter, captured word and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      dwell_q <= 8'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          sel_q   <= 2'd0;
          valid_q <= 1'b0;
          if (start) begin
            state_q <= SCAN;
            dwell_q <= RELOAD;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        SCAN: begin
          if (dwell_q != 8'd0) begin
            dwell_q <= dwell_q - 8'd1;
          end else begin
            // Last cycle of this channel's dwell: the mux has settled.
            // Bits of channels not yet reached keep their previous values.
            word_q[sel_q] <= mux_out;
            if (sel_q != 2'd3) begin
              sel_q   <= sel_q + 2'd1;
              dwell_q <= RELOAD;
            end else begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          // word and sel stay frozen until the consumer takes the word.
          if (word_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 8'd1;
            sel_q   <= 2'd0;
            if (cont) begin
              // Restart directly, without passing through IDLE.
              state_q <= SCAN;
              dwell_q <= RELOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            valid_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          sel_q   <= 2'd0;
          dwell_q <= 8'd0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign scan_cnt   = cnt_q;

endmodule
